ldst_unit: RTL and testbench

LDST_UNIT -- requirements
Module: ldst_unit

---
 rtl/ldst_unit.sv | 184 ++++++++++++++++++
 tb/tb_ldst_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ldst_unit.sv
// ldst_unit -- load/store sequencer between decode, data memory and register file.
//
// A request from decode (start) is latched in IDLE. The unit then holds a
// memory request in REQ until mem_ack. It spends one write-back cycle in WB,
// which pulses done and, for loads only, writes the register file. It then
// returns to IDLE. busy stalls fetch/decode whenever the unit is not idle.
//
// Optional feature: define LDST_TIMEOUT_EN to abandon a request after TIMEOUT
// REQ cycles without mem_ack. The abandoned request finishes with done=1,
// err=1 and no register-file write. If the macro is undefined, err is tied to 0
// and REQ waits indefinitely.
//
// Ports:
//   CLK, reset                 clock, synchronous active-high reset
//   start, is_store, addr,
//   wdata, rd                  request from decode (sampled in IDLE)
//   mem_req, mem_we,
//   mem_addr, mem_wdata        memory request (valid in REQ)
//   mem_rdata, mem_ack         memory response
//   rf_write_en, rf_waddr,
//   rf_data                    register-file write port (WB, loads only)
//   busy, done, err            status to pipeline
module ldst_unit #(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 4,
  parameter int unsigned A       = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic         is_store,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] wdata,
  input  logic [D-1:0] rd,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         rf_write_en,
  output logic [D-1:0] rf_waddr,
  output logic [W-1:0] rf_data,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_latch;
  logic           w_cap;

  logic           r_is_store;
  logic [A-1:0]   r_addr;
  logic [W-1:0]   r_wdata;
  logic [D-1:0]   r_rd;
  logic [W-1:0]   r_rdata;

`ifdef LDST_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0]  r_cnt;
  logic           r_to;
  logic           w_to_hit;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cap       = 1'b0;
`ifdef LDST_TIMEOUT_EN
    w_to_hit    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = REQ;
          w_latch     = 1'b1;
        end
      end
      REQ: begin
        // An ack in the final permitted cycle wins over the timeout.
        if (mem_ack) begin
          w_state_nxt = WB;
          w_cap       = 1'b1;
        end
`ifdef LDST_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_nxt = WB;
          w_to_hit    = 1'b1;
        end
`endif
      end
      WB: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_write_en = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (r_state != IDLE);
    mem_addr    = r_addr;
    mem_wdata   = r_wdata;
    rf_waddr    = r_rd;
    rf_data     = r_rdata;
    if (r_state == REQ) begin
      mem_req = 1'b1;
      mem_we  = r_is_store;
    end
    if (r_state == WB) begin
      done = 1'b1;
`ifdef LDST_TIMEOUT_EN
      err         = r_to;
      rf_write_en = ~r_is_store & ~r_to;
`else
      rf_write_en = ~r_is_store;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_latch) begin
        r_is_store <= is_store;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_rd       <= rd;
      end
      if (w_cap) begin
        r_rdata <= mem_rdata;
      end
    end
  end

`ifdef LDST_TIMEOUT_EN
  // r_cnt counts REQ cycles already spent without an ack.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else if (r_state == REQ && !mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_to_hit) begin
        r_to <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ldst_unit.sv
module tb_ldst_unit;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic       is_store;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [3:0] rd;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       rf_write_en;
  logic [3:0] rf_waddr;
  logic [7:0] rf_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ldst_unit #(.W(8), .D(4), .A(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .reset(reset), .start(start), .is_store(is_store),
    .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data(rf_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int n_req;
    int n_done;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    rd = '0; mem_rdata = '0; mem_ack = 1'b0;
    @(negedge CLK);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rf_we", rf_write_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_data", rf_data, 0);

    // Load, immediate ack
    start = 1'b1; is_store = 1'b0; addr = 8'h10; rd = 4'd3; wdata = 8'h77;
    tick();
    start = 1'b0;
    chk("ld1_mem_req", mem_req, 1);
    chk("ld1_mem_we", mem_we, 0);
    chk("ld1_mem_addr", mem_addr, 8'h10);
    chk("ld1_busy", busy, 1);
    chk("ld1_done_early", done, 0);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("ld1_wb_mem_req", mem_req, 0);
    chk("ld1_wb_done", done, 1);
    chk("ld1_wb_rf_we", rf_write_en, 1);
    chk("ld1_wb_rf_waddr", rf_waddr, 3);
    chk("ld1_wb_rf_data", rf_data, 8'hA5);
    chk("ld1_wb_err", err, 0);
    // start during WB must be ignored
    start = 1'b1; addr = 8'h99;
    tick();
    start = 1'b0;
    chk("wb_start_ignored_busy", busy, 0);
    chk("ld1_done_once", done, 0);
    chk("ld1_rf_we_off", rf_write_en, 0);

    // Back-to-back load at t+3, rd=0
    start = 1'b1; is_store = 1'b0; addr = 8'h11; rd = 4'd0;
    tick();
    start = 1'b0;
    chk("ld2_mem_addr", mem_addr, 8'h11);
    chk("ld2_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("ld2_rf_we", rf_write_en, 1);
    chk("ld2_rf_waddr", rf_waddr, 0);
    chk("ld2_rf_data", rf_data, 8'h3C);
    chk("ld2_done", done, 1);
    tick();

    // mem_ack while idle ignored
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_done", done, 0);

    // Store with ack after 4 cycles, plus a second start while busy
    start = 1'b1; is_store = 1'b1; addr = 8'h22; wdata = 8'h5C; rd = 4'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_mem_req", mem_req, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", mem_addr, 8'h22);
      chk("st_mem_wdata", mem_wdata, 8'h5C);
      chk("st_rf_we", rf_write_en, 0);
      chk("st_done", done, 0);
      start = (i == 1); addr = 8'h44; wdata = 8'h11; is_store = 1'b0;
      mem_ack = (i == 3);
      tick();
    end
    start = 1'b0; mem_ack = 1'b0;
    chk("st_wb_done", done, 1);
    chk("st_wb_rf_we", rf_write_en, 0);
    chk("st_wb_mem_req", mem_req, 0);
    chk("st_wb_mem_we", mem_we, 0);
    tick();
    chk("st_single_done", done, 0);
    chk("st_idle_busy", busy, 0);

    // Reset during REQ of a load to rd=7
    start = 1'b1; is_store = 1'b0; addr = 8'h30; rd = 4'd7;
    tick();
    start = 1'b0;
    chk("rq_mem_req", mem_req, 1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    chk("rq_rst_mem_req", mem_req, 0);
    chk("rq_rst_busy", busy, 0);
    chk("rq_rst_done", done, 0);
    chk("rq_rst_rf_we", rf_write_en, 0);
    chk("rq_rst_mem_addr", mem_addr, 0);
    chk("rq_rst_rf_data", rf_data, 0);
    tick();
    chk("rq_after_done", done, 0);
    chk("rq_after_rf_we", rf_write_en, 0);

    // Load with no ack
    start = 1'b1; is_store = 1'b0; addr = 8'h40; rd = 4'd5;
    tick();
    start = 1'b0;
    n_req = 0; n_done = 0;
`ifdef LDST_TIMEOUT_EN
    for (int i = 0; i < 40 && n_done == 0; i++) begin
      if (mem_req) n_req++;
      if (done) begin
        n_done++;
        chk("to_err", err, 1);
        chk("to_rf_we", rf_write_en, 0);
        chk("to_mem_req", mem_req, 0);
      end
      if (n_done == 0) tick();
    end
    chk("to_done_seen", n_done, 1);
    chk("to_req_cycles", n_req, 16);
`else
    for (int i = 0; i < 20; i++) begin
      if (mem_req) n_req++;
      if (done) n_done++;
      tick();
    end
    chk("noack_req_cycles", n_req, 20);
    chk("noack_no_done", n_done, 0);
    chk("noack_still_req", mem_req, 1);
    chk("noack_err", err, 0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
